// File: rtl/sigmoid_result_checker_if.sv
// Operand/result and status bundle for the sigmoid result checker.
// The master drives stimulus; the slave (checker) returns run status and statistics.
interface sigmoid_result_checker_if #(
    parameter int BITWIDTH  = 18,
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic                 in_valid;
    logic [BITWIDTH-1:0]  golden;
    logic [BITWIDTH-1:0]  result;
    logic                 busy;
    logic                 done;
    logic                 mismatch;
    logic [CNT_WIDTH-1:0] sample_count;
    logic [CNT_WIDTH-1:0] error_count;
    logic [BITWIDTH-1:0]  max_error;
    logic [CNT_WIDTH-1:0] first_err_index;

    modport master (
        output start, in_valid, golden, result,
        input  busy, done, mismatch, sample_count, error_count, max_error, first_err_index
    );

    modport slave (
        input  start, in_valid, golden, result,
        output busy, done, mismatch, sample_count, error_count, max_error, first_err_index
    );
endinterface

// File: rtl/sigmoid_result_checker.sv
// Compares an activation unit's output against golden values delayed by the unit latency,
// accumulating pass/fail statistics over a fixed-length run.
module sigmoid_result_checker #(
    parameter int BITWIDTH    = 18,
    parameter int LATENCY     = 1,
    parameter int TOLERANCE   = 2,
    parameter int NUM_SAMPLES = 40961,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    sigmoid_result_checker_if.slave bus
);
    localparam int ISSUE_W = $clog2(NUM_SAMPLES + 1);
    localparam logic [LATENCY-1:0] EXIT_BIT = LATENCY'(1) << (LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                             state, next_state;
    logic [ISSUE_W-1:0]                 issue_cnt;
    logic [LATENCY-1:0]                 vld_pipe;
    logic [LATENCY-1:0][BITWIDTH-1:0]   gold_pipe;
    logic                               start_run, accept, last_issue, drain_empty;
    logic                               cmp_valid, cmp_fail;
    logic [BITWIDTH:0]                  diff;
    logic                               busy_q, done_q, mismatch_q;
    logic [CNT_WIDTH-1:0]               sample_q, error_q, first_q;
    logic [BITWIDTH-1:0]                max_q;

    assign start_run   = bus.start && (state == IDLE || state == DONE);
    assign accept      = bus.in_valid && (state == RUN);
    assign last_issue  = accept && (issue_cnt == ISSUE_W'(NUM_SAMPLES - 1));
    // Only the entry being compared this cycle may remain; after this edge the pipe is empty.
    assign drain_empty = (vld_pipe & ~EXIT_BIT) == '0;
    assign cmp_valid   = vld_pipe[LATENCY-1];

    always_comb begin
        diff = '0;
        if (bus.result >= gold_pipe[LATENCY-1])
            diff = {1'b0, bus.result} - {1'b0, gold_pipe[LATENCY-1]};
        else
            diff = {1'b0, gold_pipe[LATENCY-1]} - {1'b0, bus.result};
    end

    assign cmp_fail = diff > (BITWIDTH + 1)'(TOLERANCE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start)  next_state = RUN;
            RUN:     if (last_issue) next_state = DRAIN;
            DRAIN:   if (drain_empty) next_state = DONE;
            DONE:    if (bus.start)  next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_cnt  <= '0;
            vld_pipe   <= '0;
            gold_pipe  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            sample_q   <= '0;
            error_q    <= '0;
            max_q      <= '0;
            first_q    <= '1;
        end else begin
            busy_q <= (next_state == RUN) || (next_state == DRAIN);
            done_q <= (next_state == DONE);
            if (start_run) begin
                issue_cnt  <= '0;
                vld_pipe   <= '0;
                mismatch_q <= 1'b0;
                sample_q   <= '0;
                error_q    <= '0;
                max_q      <= '0;
                first_q    <= '1;
            end else begin
                vld_pipe   <= LATENCY'({vld_pipe, accept});
                gold_pipe  <= (LATENCY * BITWIDTH)'({gold_pipe, bus.golden});
                mismatch_q <= cmp_valid && cmp_fail;
                if (accept) issue_cnt <= issue_cnt + 1'b1;
                if (cmp_valid) begin
                    sample_q <= sample_q + 1'b1;
                    if (diff > {1'b0, max_q}) max_q <= diff[BITWIDTH-1:0];
                    if (cmp_fail) begin
                        if (error_q != '1) error_q <= error_q + 1'b1;
                        if (first_q == '1) first_q <= sample_q;
                    end
                end
            end
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.mismatch        = mismatch_q;
    assign bus.sample_count    = sample_q;
    assign bus.error_count     = error_q;
    assign bus.max_error       = max_q;
    assign bus.first_err_index = first_q;
endmodule

// File: doc/sigmoid_result_checker.md
SIGMOID_RESULT_CHECKER -- requirements
Module: sigmoid_result_checker

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 18: width of the golden and result words.
REQ-002 The block SHALL have parameter LATENCY, default 1: activation-unit latency in clocks from operand issue to valid result (range 1..8).
REQ-003 The block SHALL have parameter TOLERANCE, default 2: maximum allowed |result - golden| in LSBs for a pass.
REQ-004 The block SHALL have parameter NUM_SAMPLES, default 40961: number of samples per run.
REQ-005 The block SHALL have parameter CNT_WIDTH, default 16: width of the counters and the index.
REQ-006 clock  input  1  sole clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  single-cycle pulse that begins a run.
REQ-009 in_valid  input  1  an operand was issued to the activation unit this cycle.
REQ-010 golden  input  BITWIDTH  expected result for the operand issued this cycle.
REQ-011 result  input  BITWIDTH  activation-unit output, treated as unsigned.
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  high in DONE.
REQ-014 mismatch  output  1  one-cycle pulse on a failing compare.
REQ-015 sample_count  output  CNT_WIDTH  number of compares performed.
REQ-016 error_count  output  CNT_WIDTH  number of failing compares; saturates at all-ones.
REQ-017 max_error  output  BITWIDTH  largest |result - golden| seen in the run.
REQ-018 first_err_index  output  CNT_WIDTH  compare index of the first failure; all-ones if none.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-020 Transitions:
- IDLE->RUN and DONE->RUN on start.
- RUN->DRAIN in the cycle after the NUM_SAMPLES-th accepted in_valid.
- DRAIN->DONE when the alignment pipeline holds no valid entry.
REQ-021 start SHALL be ignored in RUN and DRAIN.
REQ-022 On any start that enters RUN, all counters SHALL clear, max_error SHALL clear, first_err_index SHALL be set to all-ones and the pipeline SHALL flush, all in the same cycle.
REQ-023 in_valid SHALL be accepted only in RUN; in_valid in IDLE, DRAIN or DONE SHALL be ignored.
REQ-024 in_valid in the same cycle as start SHALL be ignored.
REQ-025 An internal issue counter SHALL count accepted in_valid; no more than NUM_SAMPLES SHALL be accepted per run.
REQ-026 golden and a valid bit SHALL enter a LATENCY-deep shift register on acceptance.
REQ-027 A compare SHALL occur in the cycle the valid bit exits the shift register, against result in that same cycle.
REQ-028 Compare arithmetic:
- diff = |result - golden|, computed unsigned in BITWIDTH+1 bits with no wrap.
- fail = diff > TOLERANCE.
REQ-029 On each compare, sample_count SHALL increment on the next edge.
REQ-030 On a failing compare:
- error_count SHALL increment, saturating at all-ones.
- mismatch SHALL pulse high the next cycle.
- first_err_index SHALL latch the pre-increment sample_count, only if it is still all-ones.
REQ-031 max_error SHALL update to diff whenever diff > max_error, whether the compare passes or fails.
REQ-032 Compares SHALL continue during DRAIN until the pipeline empties.
REQ-033 All outputs SHALL be registered.
REQ-034 Results SHALL hold stable in DONE until the next start.

Reset
REQ-035 On reset assertion, asynchronously:
- FSM goes to IDLE and the pipeline valid bits clear.
- busy=0, done=0, mismatch=0.
- sample_count=0, error_count=0, max_error=0.
- first_err_index=all-ones.
REQ-036 Reset asserted mid-RUN or mid-DRAIN SHALL abandon the run with no further compares.
REQ-037 After reset release, the block SHALL wait in IDLE for start.

Verification
REQ-038 Clean run: NUM_SAMPLES=8, LATENCY=1, result equals the golden delayed one cycle -> done=1, sample_count=8, error_count=0, max_error=0, first_err_index=0xFFFF.
REQ-039 Tolerance edge: golden=1000; result=1002 on sample 3 and result=1003 on sample 5 -> error_count=1, first_err_index=5, max_error=3, exactly one mismatch pulse.
REQ-040 Unsigned diff: golden=0 and result=0x3FFFF on sample 0 -> max_error=0x3FFFF, first_err_index=0.
REQ-041 Drain and ignore: LATENCY=3, 8 in_valid then 4 extra in_valid during DRAIN, start pulsed mid-RUN -> sample_count=8, busy falls 3 cycles after the last accepted in_valid, run not restarted.
REQ-042 Reset mid-run: reset after 4 of 8 samples -> all outputs at reset values immediately; a fresh start then completes with sample_count=8.
REQ-043 Saturation: CNT_WIDTH=3, NUM_SAMPLES=10, all samples failing -> error_count=7; sample_count wraps to 2.
